// File: rtl/bm_pkg.sv
// -----------------------------------------------------------------------------
// bm_pkg
// Shared fixed-point definitions for the multi-cell battery model.
//   Q88_FRAC / Q115_FRAC : fractional bit counts of the Q8.8 and Q1.15 formats
//   ALPHA_ONE            : 1.0 in Q1.15, upper bound applied to dt/tau
//   S16_MAX / S16_MIN    : signed 16-bit clamp limits
//   q88_t                : signed Q8.8 voltage/current word
//   state_t              : sweep sequencer states
//   sat16 / sat16_hit    : 32-bit signed to 16-bit clamp and its overflow flag
// -----------------------------------------------------------------------------
package bm_pkg;

   localparam int Q88_FRAC  = 8;
   localparam int Q115_FRAC = 15;

   localparam logic [15:0]        ALPHA_ONE = 16'h8000;
   localparam logic signed [15:0] S16_MAX   = 16'sh7FFF;
   localparam logic signed [15:0] S16_MIN   = 16'sh8000;

   typedef logic signed [15:0] q88_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Narrower signed values are sign-extended to 32 bits by the caller.
   function automatic q88_t sat16(input logic signed [31:0] x);
      if (x > 32'sd32767) begin
         return S16_MAX;
      end else if (x < -32'sd32768) begin
         return S16_MIN;
      end else begin
         return x[15:0];
      end
   endfunction

   function automatic logic sat16_hit(input logic signed [31:0] x);
      return (x > 32'sd32767) || (x < -32'sd32768);
   endfunction

endpackage

// File: rtl/bm_rc_branch.sv
// -----------------------------------------------------------------------------
// bm_rc_branch
// Combinational update of one RC polarization branch for one cell:
//   tgt = sat16(I*R >>> 8), a = min(alpha, 1.0),
//   vp' = sat16(vp + (a*(tgt-vp) >>> 15))
//   current : in  16  signed pack current, Q8.8
//   r1      : in  16  branch resistance, Q8.8 unsigned
//   alpha   : in  16  dt/tau, Q1.15 unsigned
//   vp      : in  16  present branch voltage, signed Q8.8
//   vp_new  : out 16  updated branch voltage, signed Q8.8
//   sat     : out 1   a clamp occurred in this update
// -----------------------------------------------------------------------------
module bm_rc_branch
   import bm_pkg::*;
(
   input  logic signed [15:0] current,
   input  logic [15:0]        r1,
   input  logic [15:0]        alpha,
   input  logic signed [15:0] vp,
   output logic signed [15:0] vp_new,
   output logic               sat
);

   logic signed [31:0] cur_ext;
   logic signed [31:0] r_ext;
   logic signed [31:0] tgt_full;
   logic signed [15:0] tgt;
   logic [15:0]        a;
   logic signed [31:0] a_ext;
   logic signed [16:0] diff;
   logic signed [31:0] diff_ext;
   logic signed [31:0] delta;
   logic signed [31:0] vp_sum;

   // R and alpha are magnitudes: zero-extend so bit 15 is never a sign.
   assign cur_ext  = {{16{current[15]}}, current};
   assign r_ext    = {16'd0, r1};
   assign tgt_full = (cur_ext * r_ext) >>> Q88_FRAC;
   assign tgt      = sat16(tgt_full);

   assign a        = (alpha > ALPHA_ONE) ? ALPHA_ONE : alpha;
   assign a_ext    = {16'd0, a};

   // 17 bits holds any difference of two signed 16-bit values.
   assign diff     = {tgt[15], tgt} - {vp[15], vp};
   assign diff_ext = {{15{diff[16]}}, diff};
   assign delta    = (a_ext * diff_ext) >>> Q115_FRAC;
   assign vp_sum   = {{16{vp[15]}}, vp} + delta;

   assign vp_new   = sat16(vp_sum);
   assign sat      = sat16_hit(tgt_full) | sat16_hit(vp_sum);

endmodule

// File: rtl/ocv_lut_wrapper.sv
// -----------------------------------------------------------------------------
// ocv_lut_wrapper
// Open-circuit-voltage lookup: 17-node table over SoC with linear
// interpolation between nodes. Purely combinational so the cell being
// processed gets its OCV in the same cycle.
//   soc  : in  16  SoC, Q1.15 unsigned (node pitch 0x1000)
//   vocv : out 16  open-circuit voltage, signed Q8.8
// -----------------------------------------------------------------------------
module ocv_lut_wrapper (
   input  logic [15:0]        soc,
   output logic signed [15:0] vocv
);

   // Nodes 8..16 cover SoC >= 1.0 and hold the full-charge voltage.
   function automatic logic [15:0] node(input logic [4:0] i);
      case (i)
         5'd0:    return 16'h0300;
         5'd1:    return 16'h0340;
         5'd2:    return 16'h0360;
         5'd3:    return 16'h0370;
         5'd4:    return 16'h0380;
         5'd5:    return 16'h0390;
         5'd6:    return 16'h03A8;
         5'd7:    return 16'h03D0;
         default: return 16'h0433;
      endcase
   endfunction

   logic [4:0]  seg;
   logic [15:0] lo;
   logic [15:0] hi;
   logic [15:0] span;

   assign seg  = {1'b0, soc[15:12]};
   assign lo   = node(seg);
   assign hi   = node(seg + 5'd1);
   // The table is monotone, so the span never goes negative.
   assign span = hi - lo;
   assign vocv = lo + 16'((32'(span) * 32'(soc[11:0])) >> 12);

endmodule

// File: rtl/battery_model_mc.sv
// -----------------------------------------------------------------------------
// battery_model_mc
// Time-multiplexed equivalent-circuit model for NUM_CELLS series cells with
// NUM_RC polarization branches each. One sweep = one model time step; one
// cell is evaluated per clock through a shared OCV lookup.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start_i               : request one sweep (ignored while busy)
//   clr_state_i           : zero all branch voltages (idle only, beats start)
//   current_i             : signed pack current, Q8.8 (+ = discharge)
//   soc_i                 : per-cell SoC, Q1.15, cell k at [16k+15:16k]
//   r0_i, r1_i, alpha_i   : ohmic R, per-branch R, per-branch dt/tau
//   busy_o                : sweep in progress (start cycle+1 .. last result)
//   out_valid_o/idx/v     : per-cell terminal voltage strobe
//   done_o                : pulse with the last cell result
//   v_min_o/v_max_o/sat_o : sweep summary, refreshed with done_o
// -----------------------------------------------------------------------------
module battery_model_mc
   import bm_pkg::*;
#(
   parameter int NUM_CELLS = 4,
   parameter int NUM_RC    = 2,
   parameter int IDX_W     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic                      clr_state_i,
   input  logic signed [15:0]        current_i,
   input  logic [16*NUM_CELLS-1:0]   soc_i,
   input  logic [15:0]               r0_i,
   input  logic [16*NUM_RC-1:0]      r1_i,
   input  logic [16*NUM_RC-1:0]      alpha_i,
   output logic                      busy_o,
   output logic                      out_valid_o,
   output logic [IDX_W-1:0]          out_idx_o,
   output logic signed [15:0]        out_v_o,
   output logic                      done_o,
   output logic signed [15:0]        v_min_o,
   output logic signed [15:0]        v_max_o,
   output logic                      sat_o
);

   localparam int CW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

   generate
      if (NUM_CELLS < 1 || NUM_CELLS > 16) begin : g_bad_cells
         $error("battery_model_mc: NUM_CELLS must be 1..16");
      end
      if (NUM_RC != 1 && NUM_RC != 2) begin : g_bad_rc
         $error("battery_model_mc: NUM_RC must be 1 or 2");
      end
      if (IDX_W < CW) begin : g_bad_idx
         $error("battery_model_mc: IDX_W too narrow for NUM_CELLS");
      end
   endgenerate

   state_t                  state_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic signed [15:0]      cur_reg;
   logic [16*NUM_CELLS-1:0] soc_reg;
   logic [15:0]             r0_reg;
   logic [16*NUM_RC-1:0]    r1_reg;
   logic [16*NUM_RC-1:0]    alpha_reg;
   logic signed [15:0]      vp_reg [NUM_CELLS][NUM_RC];
   logic                    sticky_reg;
   logic signed [15:0]      min_reg;
   logic signed [15:0]      max_reg;

   logic                    run;
   logic                    idle_free;
   logic                    clr_ok;
   logic                    start_ok;
   logic                    last;
   logic                    first;
   logic [CW-1:0]           cell_sel;
   logic [15:0]             soc_cur;
   logic signed [15:0]      vocv;
   logic signed [31:0]      cur_ext;
   logic signed [31:0]      ir0_full;
   logic signed [15:0]      ir0;
   logic signed [15:0]      vp_new [NUM_RC];
   logic [NUM_RC-1:0]       br_sat;
   logic signed [18:0]      v_acc;
   logic signed [31:0]      v_full;
   logic signed [15:0]      v_cell;
   logic                    cell_sat;
   logic signed [15:0]      min_next;
   logic signed [15:0]      max_next;

   assign run       = (state_reg == ST_RUN);
   // busy_o stays high one cycle past RUN while the last result drains.
   assign idle_free = (state_reg == ST_IDLE) && !busy_o;
   assign clr_ok    = idle_free && clr_state_i;
   assign start_ok  = idle_free && start_i && !clr_state_i;
   assign last      = (idx_reg == IDX_W'(NUM_CELLS - 1));
   assign first     = (idx_reg == '0);
   assign cell_sel  = idx_reg[CW-1:0];
   assign soc_cur   = soc_reg[16*cell_sel +: 16];

   ocv_lut_wrapper u_ocv (
      .soc  (soc_cur),
      .vocv (vocv)
   );

   assign cur_ext  = {{16{cur_reg[15]}}, cur_reg};
   assign ir0_full = (cur_ext * $signed({16'd0, r0_reg})) >>> Q88_FRAC;
   assign ir0      = sat16(ir0_full);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RC; gi++) begin : g_branch
         bm_rc_branch u_branch (
            .current (cur_reg),
            .r1      (r1_reg[16*gi +: 16]),
            .alpha   (alpha_reg[16*gi +: 16]),
            .vp      (vp_reg[cell_sel][gi]),
            .vp_new  (vp_new[gi]),
            .sat     (br_sat[gi])
         );
      end
   endgenerate

   // 19 bits cover vocv - ir0 - two branch voltages without wrap.
   always_comb begin
      v_acc = {{3{vocv[15]}}, vocv} - {{3{ir0[15]}}, ir0};
      for (int j = 0; j < NUM_RC; j++) begin
         v_acc = v_acc - {{3{vp_new[j][15]}}, vp_new[j]};
      end
   end

   assign v_full   = {{13{v_acc[18]}}, v_acc};
   assign v_cell   = sat16(v_full);
   assign cell_sat = sat16_hit(ir0_full) | (|br_sat) | sat16_hit(v_full);

   // Strict compares so a tie keeps the earlier cell's value.
   assign min_next = (first || (v_cell < min_reg)) ? v_cell : min_reg;
   assign max_next = (first || (v_cell > max_reg)) ? v_cell : max_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            for (int j = 0; j < NUM_RC; j++) begin
               vp_reg[i][j] <= '0;
            end
         end
      end else if (clr_ok) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            for (int j = 0; j < NUM_RC; j++) begin
               vp_reg[i][j] <= '0;
            end
         end
      end else if (run) begin
         for (int j = 0; j < NUM_RC; j++) begin
            vp_reg[cell_sel][j] <= vp_new[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         idx_reg     <= '0;
         cur_reg     <= '0;
         soc_reg     <= '0;
         r0_reg      <= '0;
         r1_reg      <= '0;
         alpha_reg   <= '0;
         sticky_reg  <= 1'b0;
         min_reg     <= '0;
         max_reg     <= '0;
         busy_o      <= 1'b0;
         out_valid_o <= 1'b0;
         out_idx_o   <= '0;
         out_v_o     <= '0;
         done_o      <= 1'b0;
         v_min_o     <= '0;
         v_max_o     <= '0;
         sat_o       <= 1'b0;
      end else begin
         out_valid_o <= 1'b0;
         done_o      <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               busy_o <= 1'b0;
               if (start_ok) begin
                  cur_reg    <= current_i;
                  soc_reg    <= soc_i;
                  r0_reg     <= r0_i;
                  r1_reg     <= r1_i;
                  alpha_reg  <= alpha_i;
                  idx_reg    <= '0;
                  sticky_reg <= 1'b0;
                  busy_o     <= 1'b1;
                  state_reg  <= ST_RUN;
               end
            end
            ST_RUN: begin
               busy_o      <= 1'b1;
               out_valid_o <= 1'b1;
               out_idx_o   <= idx_reg;
               out_v_o     <= v_cell;
               min_reg     <= min_next;
               max_reg     <= max_next;
               sticky_reg  <= sticky_reg | cell_sat;
               if (last) begin
                  done_o    <= 1'b1;
                  v_min_o   <= min_next;
                  v_max_o   <= max_next;
                  sat_o     <= sticky_reg | cell_sat;
                  idx_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_battery_model_mc.sv
// -----------------------------------------------------------------------------
// tb_battery_model_mc
// Directed and randomized sweeps of battery_model_mc (4 cells, 2 branches)
// against an integer-arithmetic model of the cell equations.
// -----------------------------------------------------------------------------
module tb_battery_model_mc;

   localparam int NC = 4;
   localparam int NR = 2;
   localparam int IW = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start_i;
   logic                 clr_state_i;
   logic signed [15:0]   current_i;
   logic [16*NC-1:0]     soc_i;
   logic [15:0]          r0_i;
   logic [16*NR-1:0]     r1_i;
   logic [16*NR-1:0]     alpha_i;
   logic                 busy_o;
   logic                 out_valid_o;
   logic [IW-1:0]        out_idx_o;
   logic signed [15:0]   out_v_o;
   logic                 done_o;
   logic signed [15:0]   v_min_o;
   logic signed [15:0]   v_max_o;
   logic                 sat_o;

   always #5 clk = ~clk;

   battery_model_mc #(.NUM_CELLS(NC), .NUM_RC(NR), .IDX_W(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .clr_state_i (clr_state_i),
      .current_i   (current_i),
      .soc_i       (soc_i),
      .r0_i        (r0_i),
      .r1_i        (r1_i),
      .alpha_i     (alpha_i),
      .busy_o      (busy_o),
      .out_valid_o (out_valid_o),
      .out_idx_o   (out_idx_o),
      .out_v_o     (out_v_o),
      .done_o      (done_o),
      .v_min_o     (v_min_o),
      .v_max_o     (v_max_o),
      .sat_o       (sat_o)
   );

   int checks   = 0;
   int failures = 0;
   int sweep_no = 0;

   // OCV curve nodes at SoC = n/8, linear in between.
   int ocv_tbl [17] = '{'h0300, 'h0340, 'h0360, 'h0370, 'h0380, 'h0390,
                        'h03A8, 'h03D0, 'h0433, 'h0433, 'h0433, 'h0433,
                        'h0433, 'h0433, 'h0433, 'h0433, 'h0433};

   int m_vp [NC][NR];
   int m_v  [NC];
   int m_min;
   int m_max;
   bit m_sat;
   bit msat;

   function automatic int clamp16(longint x);
      if (x > 32767) begin
         msat = 1'b1;
         return 32767;
      end
      if (x < -32768) begin
         msat = 1'b1;
         return -32768;
      end
      return int'(x);
   endfunction

   function automatic int ocv_of(int soc);
      int i;
      int f;
      i = soc / 4096;
      f = soc % 4096;
      return ocv_tbl[i] + (((ocv_tbl[i+1] - ocv_tbl[i]) * f) / 4096);
   endfunction

   // One model time step using the values currently on the inputs.
   task automatic model_sweep();
      int cur;
      int r0;
      int r1;
      int al;
      int ir0;
      int tgt;
      int sum;
      int v;
      cur  = current_i;
      r0   = int'(r0_i);
      msat = 1'b0;
      ir0  = clamp16((longint'(cur) * r0) >>> 8);
      for (int k = 0; k < NC; k++) begin
         sum = 0;
         for (int j = 0; j < NR; j++) begin
            r1  = int'(r1_i[16*j +: 16]);
            al  = int'(alpha_i[16*j +: 16]);
            if (al > 32768) al = 32768;
            tgt = clamp16((longint'(cur) * r1) >>> 8);
            m_vp[k][j] = clamp16(longint'(m_vp[k][j]) +
                         ((longint'(al) * (tgt - m_vp[k][j])) >>> 15));
            sum += m_vp[k][j];
         end
         v = clamp16(longint'(ocv_of(int'(soc_i[16*k +: 16]))) - ir0 - sum);
         m_v[k] = v;
         if (k == 0 || v < m_min) m_min = v;
         if (k == 0 || v > m_max) m_max = v;
      end
      m_sat = msat;
   endtask

   task automatic model_clear();
      for (int k = 0; k < NC; k++)
         for (int j = 0; j < NR; j++)
            m_vp[k][j] = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},  32'(busy_o), 0);
      chk({tag, "_valid"}, 32'(out_valid_o), 0);
      chk({tag, "_done"},  32'(done_o), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk_idle_outputs(tag);
      chk({tag, "_idx"},  32'(out_idx_o), 0);
      chk({tag, "_v"},    out_v_o, 0);
      chk({tag, "_vmin"}, v_min_o, 0);
      chk({tag, "_vmax"}, v_max_o, 0);
      chk({tag, "_sat"},  32'(sat_o), 0);
   endtask

   task automatic rand_inputs();
      current_i = 16'($urandom);
      soc_i     = {$urandom, $urandom};
      r0_i      = 16'($urandom_range(0, 16'h0400));
      r1_i      = {16'($urandom_range(0, 16'h0800)), 16'($urandom)};
      alpha_i   = {16'($urandom), 16'($urandom_range(0, 16'h8000))};
   endtask

   // Runs one sweep from the next negedge and checks every cycle of it.
   task automatic sweep(input bit spurious, input bit scramble);
      string t;
      @(negedge clk);
      start_i = 1'b1;
      model_sweep();
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 1; c <= NC + 2; c++) begin
         if (c > 1) @(negedge clk);
         t = $sformatf("s%0d_c%0d", sweep_no, c);
         chk({t, "_busy"},  32'(busy_o), 32'(c <= NC + 1));
         chk({t, "_valid"}, 32'(out_valid_o), 32'(c >= 2 && c <= NC + 1));
         chk({t, "_done"},  32'(done_o), 32'(c == NC + 1));
         if (c >= 2 && c <= NC + 1) begin
            chk({t, "_idx"}, 32'(out_idx_o), c - 2);
            chk({t, "_v"},   out_v_o, m_v[c-2]);
         end
         if (c == NC + 1) begin
            chk({t, "_vmin"}, v_min_o, m_min);
            chk({t, "_vmax"}, v_max_o, m_max);
            chk({t, "_sat"},  32'(sat_o), 32'(m_sat));
         end
         if (c == 1 && scramble) rand_inputs();
         if (c == 2 && spurious) start_i = 1'b1;
         if (c == 3) start_i = 1'b0;
      end
      if (spurious) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle_outputs($sformatf("s%0d_after%0d", sweep_no, c));
         end
      end
      $display("sweep %0d: v0=%0h v1=%0h v2=%0h v3=%0h min=%0h max=%0h sat=%0d",
               sweep_no, m_v[0], m_v[1], m_v[2], m_v[3], m_min, m_max, m_sat);
      sweep_no++;
   endtask

   initial begin
      rst_n       = 1'b0;
      start_i     = 1'b0;
      clr_state_i = 1'b0;
      current_i   = '0;
      soc_i       = '0;
      r0_i        = '0;
      r1_i        = '0;
      alpha_i     = '0;
      model_clear();
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Zero current: terminal voltage is the OCV of each cell.
      soc_i   = {16'h7FFF, 16'h2A00, 16'h6800, 16'h1000};
      r0_i    = 16'h0123;
      r1_i    = {16'h0456, 16'h0789};
      alpha_i = {16'h1000, 16'h2000};
      sweep(1'b0, 1'b0);

      // Single active branch: vp 0x80 then 0xC0.
      current_i = 16'sh0100;
      r0_i      = 16'h0080;
      r1_i      = {16'h0000, 16'h0100};
      alpha_i   = {16'h0000, 16'h4000};
      sweep(1'b0, 1'b0);
      sweep(1'b0, 1'b0);

      // Clear alone in idle: no sweep starts.
      @(negedge clk);
      clr_state_i = 1'b1;
      model_clear();
      @(negedge clk);
      clr_state_i = 1'b0;
      chk_idle_outputs("clr_only");

      // alpha above 1.0 is limited to exactly 1.0.
      alpha_i = {16'h0000, 16'hFFFF};
      sweep(1'b0, 1'b0);

      // Heavy load: ohmic drop and branches clamp.
      current_i = 16'sh7FFF;
      r0_i      = 16'h7FFF;
      r1_i      = {16'h7FFF, 16'h7FFF};
      alpha_i   = {16'h8000, 16'h8000};
      soc_i     = {16'h0800, 16'h0000, 16'h0400, 16'h0200};
      sweep(1'b0, 1'b0);

      // Clean step afterwards clears sat_o.
      current_i = '0;
      sweep(1'b0, 1'b0);

      // Clear together with start: clear wins, nothing runs.
      current_i = 16'sh0300;
      r0_i      = 16'h0040;
      r1_i      = {16'h0200, 16'h0100};
      alpha_i   = {16'h2000, 16'h3000};
      @(negedge clk);
      clr_state_i = 1'b1;
      start_i     = 1'b1;
      model_clear();
      @(negedge clk);
      clr_state_i = 1'b0;
      start_i     = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk_idle_outputs($sformatf("clr_start%0d", c));
         @(negedge clk);
      end

      // Stray start mid-sweep is ignored; inputs scrambled mid-sweep.
      sweep(1'b1, 1'b1);

      for (int n = 0; n < 6; n++) begin
         rand_inputs();
         sweep(n[0], n[1]);
      end

      // Reset in cycle 3 of a sweep aborts it.
      current_i = 16'sh0200;
      r0_i      = 16'h0020;
      r1_i      = {16'h0100, 16'h0300};
      alpha_i   = {16'h4000, 16'h6000};
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      model_clear();
      repeat (2) @(negedge clk);
      chk_all_zero("midrst_hold");
      rst_n = 1'b1;
      sweep(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
